// File: rtl/clock_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// clock_pkg : mode/digit encodings and timing defaults for the alarm clock.
// Rev 1.0
// ---------------------------------------------------------------------------
package clock_pkg;

   typedef enum logic [1:0] {
      MODE_RUN       = 2'b00,
      MODE_SET_TIME  = 2'b01,
      MODE_SET_ALARM = 2'b10,
      MODE_RINGING   = 2'b11
   } mode_t;

   localparam int DIG_MIN_LO = 0;
   localparam int DIG_MIN_HI = 1;
   localparam int DIG_HR_LO  = 2;
   localparam int DIG_HR_HI  = 3;

   localparam int DEF_REPEAT_DELAY  = 50_000_000;
   localparam int DEF_REPEAT_PERIOD = 10_000_000;
   localparam int DEF_RING_MINUTES  = 5;

endpackage
`default_nettype wire

// File: rtl/btn_repeat.sv
`default_nettype none
// ---------------------------------------------------------------------------
// btn_repeat : press edge detect plus hold-to-repeat strobe generator.
// Rev 1.0
// ---------------------------------------------------------------------------
module btn_repeat #(
   parameter int REPEAT_DELAY  = 8,
   parameter int REPEAT_PERIOD = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic btn,
   input  logic other,
   input  logic clr,
   output logic press,
   output logic strobe
);

   localparam int CW = $clog2(REPEAT_DELAY + 1);
   localparam logic [CW-1:0] LAST   = CW'(REPEAT_DELAY - 1);
   localparam logic [CW-1:0] RELOAD = CW'(REPEAT_DELAY - REPEAT_PERIOD);

   logic          btn_q;
   logic [CW-1:0] cnt;
   logic          hold;

   // cnt holds the number of held cycles before the current one, so the
   // press cycle sees 0 and the REPEAT_DELAY-th held cycle sees LAST.
   assign hold   = btn & ~other;
   assign press  = btn & ~btn_q;
   assign strobe = hold & ~clr & (press | (cnt == LAST));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         btn_q <= 1'b0;
         cnt   <= '0;
      end else begin
         btn_q <= btn;
         if (!hold || clr)
            cnt <= '0;
         else if (cnt == LAST)
            cnt <= RELOAD;
         else
            cnt <= cnt + CW'(1);
      end
   end

endmodule
`default_nettype wire

// File: rtl/clock_mode_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// clock_mode_ctrl : alarm-clock mode FSM, set cursor, digit strobes, buzzer.
// Rev 1.0
// ---------------------------------------------------------------------------
import clock_pkg::*;

module clock_mode_ctrl #(
   parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
   parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD,
   parameter int RING_MINUTES  = DEF_RING_MINUTES
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick_min,
   input  logic       btn_c,
   input  logic       btn_l,
   input  logic       btn_r,
   input  logic       btn_u,
   input  logic       btn_d,
   input  logic [3:0] time_tc,
   input  logic       alarm_match,
   output logic [3:0] time_en,
   output logic       time_up,
   output logic       time_down,
   output logic [3:0] alarm_en,
   output logic       alarm_up,
   output logic       alarm_down,
   output logic [1:0] mode,
   output logic [1:0] cursor,
   output logic       alarm_armed,
   output logic       buzzer
);

   localparam int RW = $clog2(RING_MINUTES + 1);
   localparam logic [RW-1:0] RING_LAST = RW'(RING_MINUTES - 1);

   mode_t         state;
   logic [1:0]    cur;
   logic          armed;
   logic          buzz;
   logic [RW-1:0] ring_cnt;
   logic          c_q, l_q, r_q, match_q;

   logic press_c, press_l, press_r, press_u, press_d;
   logic strobe_u, strobe_d, up, down;
   logic any_press, match_rise, trigger, ring_exit, mode_chg, allow_ud;
   logic [3:0] carry;

   // hr_hi is the top digit: its terminal flag never feeds a carry.
   wire unused_hr_hi_tc = time_tc[DIG_HR_HI];

   assign press_c    = btn_c & ~c_q;
   assign press_l    = btn_l & ~l_q;
   assign press_r    = btn_r & ~r_q;
   assign any_press  = press_c | press_l | press_r | press_u | press_d;
   assign match_rise = alarm_match & ~match_q;

   assign trigger   = (state == MODE_RUN) & armed & match_rise & ~press_c;
   assign ring_exit = (state == MODE_RINGING) &
                      (any_press | (tick_min & (ring_cnt == RING_LAST)));
   assign mode_chg  = press_c | trigger | ring_exit;

   btn_repeat #(
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD)
   ) u_rep_up (
      .clk    (clk),
      .reset  (reset),
      .btn    (btn_u),
      .other  (btn_d),
      .clr    (mode_chg),
      .press  (press_u),
      .strobe (strobe_u)
   );

   btn_repeat #(
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD)
   ) u_rep_down (
      .clk    (clk),
      .reset  (reset),
      .btn    (btn_d),
      .other  (btn_u),
      .clr    (mode_chg),
      .press  (press_d),
      .strobe (strobe_d)
   );

   // Cursor and mode presses outrank up/down in the same cycle.
   assign allow_ud = ~press_l & ~press_r;
   assign up       = strobe_u & allow_ud;
   assign down     = strobe_d & allow_ud;

   assign carry[DIG_MIN_LO] = 1'b1;
   assign carry[DIG_MIN_HI] = time_tc[DIG_MIN_LO];
   assign carry[DIG_HR_LO]  = &time_tc[DIG_MIN_HI:DIG_MIN_LO];
   assign carry[DIG_HR_HI]  = &time_tc[DIG_HR_LO:DIG_MIN_LO];

   always_comb begin
      time_en    = 4'b0000;
      time_up    = 1'b0;
      time_down  = 1'b0;
      alarm_en   = 4'b0000;
      alarm_up   = 1'b0;
      alarm_down = 1'b0;
      if (state == MODE_SET_TIME) begin
         if (up | down)
            time_en[cur] = 1'b1;
         time_up   = up;
         time_down = down;
      end else if (tick_min) begin
         time_en = carry;
         time_up = 1'b1;
      end
      if ((state == MODE_SET_ALARM) && (up | down)) begin
         alarm_en[cur] = 1'b1;
         alarm_up      = up;
         alarm_down    = down;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= MODE_RUN;
         cur      <= 2'd0;
         armed    <= 1'b0;
         buzz     <= 1'b0;
         ring_cnt <= '0;
         c_q      <= 1'b0;
         l_q      <= 1'b0;
         r_q      <= 1'b0;
         match_q  <= 1'b0;
      end else begin
         c_q     <= btn_c;
         l_q     <= btn_l;
         r_q     <= btn_r;
         match_q <= alarm_match;
         case (state)
            MODE_RUN: begin
               if (press_c) begin
                  state <= MODE_SET_TIME;
                  cur   <= 2'd0;
               end else if (trigger) begin
                  state <= MODE_RINGING;
                  buzz  <= 1'b1;
               end else if (press_l & ~press_r) begin
                  armed <= ~armed;
               end
            end
            MODE_SET_TIME, MODE_SET_ALARM: begin
               if (press_c) begin
                  state <= (state == MODE_SET_TIME) ? MODE_SET_ALARM : MODE_RUN;
                  cur   <= 2'd0;
               end else if (press_r & ~press_l) begin
                  cur <= cur + 2'd1;
               end else if (press_l & ~press_r) begin
                  cur <= cur - 2'd1;
               end
            end
            MODE_RINGING: begin
               if (ring_exit) begin
                  state    <= MODE_RUN;
                  buzz     <= 1'b0;
                  ring_cnt <= '0;
               end else if (tick_min) begin
                  ring_cnt <= ring_cnt + RW'(1);
               end
            end
            default: state <= MODE_RUN;
         endcase
      end
   end

   assign mode        = state;
   assign cursor      = cur;
   assign alarm_armed = armed;
   assign buzzer      = buzz;

endmodule
`default_nettype wire

// File: tb/tb_clock_mode_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_clock_mode_ctrl : self-checking bench with a behavioural reference model.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_clock_mode_ctrl;

   localparam int D  = 8;
   localparam int P  = 4;
   localparam int RM = 5;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       tick_min = 1'b0;
   logic       btn_c = 1'b0, btn_l = 1'b0, btn_r = 1'b0, btn_u = 1'b0, btn_d = 1'b0;
   logic [3:0] time_tc = 4'b0000;
   logic       alarm_match = 1'b0;
   logic [3:0] time_en, alarm_en;
   logic       time_up, time_down, alarm_up, alarm_down;
   logic [1:0] mode, cursor;
   logic       alarm_armed, buzzer;

   int checks = 0;
   int failures = 0;

   clock_mode_ctrl #(
      .REPEAT_DELAY  (D),
      .REPEAT_PERIOD (P),
      .RING_MINUTES  (RM)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .tick_min    (tick_min),
      .btn_c       (btn_c),
      .btn_l       (btn_l),
      .btn_r       (btn_r),
      .btn_u       (btn_u),
      .btn_d       (btn_d),
      .time_tc     (time_tc),
      .alarm_match (alarm_match),
      .time_en     (time_en),
      .time_up     (time_up),
      .time_down   (time_down),
      .alarm_en    (alarm_en),
      .alarm_up    (alarm_up),
      .alarm_down  (alarm_down),
      .mode        (mode),
      .cursor      (cursor),
      .alarm_armed (alarm_armed),
      .buzzer      (buzzer)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Minute carry: digit k advances when every lower digit is at its terminal.
   function automatic logic [3:0] exp_chain(input logic [3:0] tc);
      int k = 0;
      while (k < 3 && tc[k]) k++;
      return 4'((1 << (k + 1)) - 1);
   endfunction

   // Strobes over a hold of len cycles: at cycle 1, at D, then every P.
   function automatic int exp_repeats(input int len);
      int k = 0;
      for (int n = 1; n <= len; n++)
         if (n == 1 || (n >= D && (n - D) % P == 0)) k++;
      return k;
   endfunction

   task automatic test_reset();
      #2;
      checks++;
      if ({mode, cursor, alarm_armed, buzzer} !== 6'b0) begin
         failures++;
         $display("FAIL reset_state mode=%b cursor=%b armed=%b buzzer=%b exp all 0",
                  mode, cursor, alarm_armed, buzzer);
      end
      checks++;
      if ({time_en, alarm_en, time_up, time_down, alarm_up, alarm_down} !== 12'b0) begin
         failures++;
         $display("FAIL reset_strobes time_en=%b alarm_en=%b exp 0", time_en, alarm_en);
      end
      @(negedge clk);
      reset = 1'b1;
      cyc();
   endtask

   task automatic test_run_chain();
      logic [3:0] tc;
      time_tc  = 4'b0111;
      tick_min = 1'b1;
      #1;
      checks++;
      if (time_en !== 4'b1111 || time_up !== 1'b1 || time_down !== 1'b0) begin
         failures++;
         $display("FAIL chain_0111 time_en=%b up=%b down=%b exp 1111/1/0", time_en, time_up, time_down);
      end
      cyc();
      tick_min = 1'b0;
      #1;
      checks++;
      if (time_en !== 4'b0000 || time_up !== 1'b0) begin
         failures++;
         $display("FAIL chain_one_cycle time_en=%b up=%b exp 0000/0", time_en, time_up);
      end
      time_tc  = 4'b0001;
      tick_min = 1'b1;
      #1;
      checks++;
      if (time_en !== 4'b0011) begin
         failures++;
         $display("FAIL chain_0001 time_en=%b exp 0011", time_en);
      end
      cyc();
      tick_min = 1'b0;
      for (int i = 0; i < 16; i++) begin
         tc       = 4'($urandom_range(0, 15));
         time_tc  = tc;
         tick_min = 1'($urandom_range(0, 1));
         #1;
         checks++;
         if (time_en !== (tick_min ? exp_chain(tc) : 4'b0000) || time_up !== tick_min) begin
            failures++;
            $display("FAIL chain_rand tc=%b tick=%b time_en=%b exp %b", tc, tick_min,
                     time_en, tick_min ? exp_chain(tc) : 4'b0000);
         end
         cyc();
      end
      tick_min = 1'b0;
      time_tc  = 4'b0000;
      cyc();
   endtask

   task automatic test_set_cursor();
      logic [1:0] exp_cur [5] = '{2'd1, 2'd2, 2'd1, 2'd0, 2'd3};
      logic       is_r    [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      btn_c = 1'b1;
      cyc();
      btn_c = 1'b0;
      checks++;
      if (mode !== 2'b01 || cursor !== 2'd0) begin
         failures++;
         $display("FAIL enter_set_time mode=%b cursor=%0d exp 01/0", mode, cursor);
      end
      cyc();
      for (int i = 0; i < 5; i++) begin
         btn_r = is_r[i];
         btn_l = ~is_r[i];
         cyc();
         btn_r = 1'b0;
         btn_l = 1'b0;
         cyc();
         checks++;
         if (cursor !== exp_cur[i]) begin
            failures++;
            $display("FAIL cursor_step%0d cursor=%0d exp %0d", i, cursor, exp_cur[i]);
         end
      end
      btn_u = 1'b1;
      #1;
      checks++;
      if (time_en !== 4'b1000 || time_up !== 1'b1 || time_down !== 1'b0 || alarm_en !== 4'b0) begin
         failures++;
         $display("FAIL set_up_strobe time_en=%b up=%b down=%b alarm_en=%b exp 1000/1/0/0000",
                  time_en, time_up, time_down, alarm_en);
      end
      cyc();
      checks++;
      if (time_en !== 4'b0000 || time_up !== 1'b0) begin
         failures++;
         $display("FAIL set_up_one_cycle time_en=%b up=%b exp 0000/0", time_en, time_up);
      end
      btn_u = 1'b0;
      cyc();
      tick_min = 1'b1;
      #1;
      checks++;
      if (time_en !== 4'b0000 || time_up !== 1'b0) begin
         failures++;
         $display("FAIL set_time_frozen time_en=%b up=%b exp 0000/0", time_en, time_up);
      end
      cyc();
      tick_min = 1'b0;
      cyc();
   endtask

   task automatic test_random_set();
      int cur = 3;
      int b;
      logic [3:0] exp_en;
      for (int i = 0; i < 40; i++) begin
         b     = $urandom_range(0, 3);
         btn_l = (b == 0);
         btn_r = (b == 1);
         btn_u = (b == 2);
         btn_d = (b == 3);
         #1;
         exp_en = (b >= 2) ? 4'(1 << cur) : 4'b0000;
         checks++;
         if (time_en !== exp_en || time_up !== (b == 2) || time_down !== (b == 3)) begin
            failures++;
            $display("FAIL rand_set_strobe i=%0d btn=%0d time_en=%b up=%b down=%b exp %b",
                     i, b, time_en, time_up, time_down, exp_en);
         end
         cyc();
         {btn_l, btn_r, btn_u, btn_d} = 4'b0000;
         cyc();
         if (b == 0) cur = (cur + 3) % 4;
         if (b == 1) cur = (cur + 1) % 4;
         checks++;
         if (cursor !== 2'(cur)) begin
            failures++;
            $display("FAIL rand_set_cursor i=%0d cursor=%0d exp %0d", i, cursor, cur);
         end
      end
   endtask

   task automatic test_c_u_same();
      btn_c = 1'b1;
      btn_u = 1'b1;
      #1;
      checks++;
      if (time_en !== 4'b0000 || time_up !== 1'b0 || alarm_en !== 4'b0000) begin
         failures++;
         $display("FAIL c_u_same_strobe time_en=%b up=%b alarm_en=%b exp 0", time_en, time_up, alarm_en);
      end
      cyc();
      btn_c = 1'b0;
      btn_u = 1'b0;
      checks++;
      if (mode !== 2'b10 || cursor !== 2'd0) begin
         failures++;
         $display("FAIL c_u_same_mode mode=%b cursor=%0d exp 10/0", mode, cursor);
      end
      cyc();
   endtask

   task automatic test_repeat();
      int len, got, bad;
      for (int t = 0; t < 4; t++) begin
         len   = (t == 0) ? D + 2 * P : $urandom_range(1, 30);
         got   = 0;
         bad   = 0;
         btn_d = 1'b1;
         for (int i = 0; i < len; i++) begin
            #1;
            if (alarm_down) got++;
            if (alarm_up || time_en !== 4'b0 || alarm_en !== (alarm_down ? 4'b0001 : 4'b0000)) bad++;
            cyc();
         end
         btn_d = 1'b0;
         cyc();
         cyc();
         checks++;
         if (got !== exp_repeats(len) || bad !== 0) begin
            failures++;
            $display("FAIL repeat_down len=%0d strobes=%0d exp %0d bad_cycles=%0d",
                     len, got, exp_repeats(len), bad);
         end
      end
      got   = 0;
      btn_u = 1'b1;
      btn_d = 1'b1;
      for (int i = 0; i < D + 2 * P; i++) begin
         #1;
         if (alarm_up || alarm_down || alarm_en !== 4'b0) got++;
         cyc();
      end
      btn_u = 1'b0;
      btn_d = 1'b0;
      cyc();
      checks++;
      if (got !== 0) begin
         failures++;
         $display("FAIL repeat_both strobe_cycles=%0d exp 0", got);
      end
      btn_c = 1'b1;
      cyc();
      btn_c = 1'b0;
      cyc();
      checks++;
      if (mode !== 2'b00) begin
         failures++;
         $display("FAIL set_alarm_to_run mode=%b exp 00", mode);
      end
   endtask

   task automatic test_alarm();
      btn_l = 1'b1;
      cyc();
      btn_l = 1'b0;
      cyc();
      checks++;
      if (alarm_armed !== 1'b1) begin
         failures++;
         $display("FAIL arm armed=%b exp 1", alarm_armed);
      end
      alarm_match = 1'b1;
      cyc();
      checks++;
      if (mode !== 2'b11 || buzzer !== 1'b1) begin
         failures++;
         $display("FAIL ring_start mode=%b buzzer=%b exp 11/1", mode, buzzer);
      end
      for (int k = 1; k <= RM; k++) begin
         tick_min = 1'b1;
         #1;
         checks++;
         if (time_en !== 4'b0001 || time_up !== 1'b1) begin
            failures++;
            $display("FAIL ring_chain k=%0d time_en=%b up=%b exp 0001/1", k, time_en, time_up);
         end
         cyc();
         tick_min = 1'b0;
         cyc();
         checks++;
         if (mode !== ((k < RM) ? 2'b11 : 2'b00) || buzzer !== (k < RM)) begin
            failures++;
            $display("FAIL ring_tick k=%0d mode=%b buzzer=%b exp %b/%b", k, mode, buzzer,
                     (k < RM) ? 2'b11 : 2'b00, k < RM);
         end
      end
      checks++;
      if (alarm_armed !== 1'b1) begin
         failures++;
         $display("FAIL ring_keep_armed armed=%b exp 1", alarm_armed);
      end
      alarm_match = 1'b0;
      cyc();
      alarm_match = 1'b1;
      cyc();
      checks++;
      if (mode !== 2'b11) begin
         failures++;
         $display("FAIL ring_again mode=%b exp 11", mode);
      end
      btn_u = 1'b1;
      #1;
      checks++;
      if (time_en !== 4'b0000 || time_up !== 1'b0 || alarm_en !== 4'b0000) begin
         failures++;
         $display("FAIL ring_press_strobe time_en=%b up=%b exp 0000/0", time_en, time_up);
      end
      cyc();
      btn_u = 1'b0;
      checks++;
      if (mode !== 2'b00 || buzzer !== 1'b0 || alarm_armed !== 1'b1) begin
         failures++;
         $display("FAIL ring_press_exit mode=%b buzzer=%b armed=%b exp 00/0/1", mode, buzzer, alarm_armed);
      end
      alarm_match = 1'b0;
      cyc();
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 2; i++) begin
         btn_c = 1'b1;
         cyc();
         btn_c = 1'b0;
         cyc();
      end
      for (int i = 0; i < 2; i++) begin
         btn_r = 1'b1;
         cyc();
         btn_r = 1'b0;
         cyc();
      end
      checks++;
      if (mode !== 2'b10 || cursor !== 2'd2) begin
         failures++;
         $display("FAIL pre_reset mode=%b cursor=%0d exp 10/2", mode, cursor);
      end
      #1;
      reset = 1'b0;
      #1;
      checks++;
      if ({mode, cursor, alarm_armed, buzzer} !== 6'b0 ||
          {time_en, alarm_en, time_up, time_down, alarm_up, alarm_down} !== 12'b0) begin
         failures++;
         $display("FAIL async_reset mode=%b cursor=%0d armed=%b buzzer=%b exp all 0",
                  mode, cursor, alarm_armed, buzzer);
      end
      @(negedge clk);
      reset = 1'b1;
      cyc();
   endtask

   initial begin
      test_reset();
      test_run_chain();
      test_set_cursor();
      test_random_set();
      test_c_u_same();
      test_repeat();
      test_alarm();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
